// File: rtl/serial_adder_n_bit.sv
// Bit-serial N-bit adder, LSB first, with one full-adder cell and a carry flop; N cycles from busy to done.
// A start request is accepted in IDLE or DONE and ignored while busy; results hold until the next operation finishes.
module serial_adder_n_bit #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         overflow
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [N-1:0]   a_sh;
   logic [N-1:0]   b_sh;
   logic           carry;
   logic [CW-1:0]  cnt;
   logic           accept;
   logic           last_bit;
   logic           sum_bit;
   logic           c_next;
   logic [N-1:0]   sum_msb;

   assign accept   = start && (state != RUN);
   assign last_bit = (cnt == CW'(N - 1));

   // Single full-adder cell operating on the operand LSBs.
   assign sum_bit = a_sh[0] ^ b_sh[0] ^ carry;
   assign c_next  = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

   always_comb begin
      sum_msb        = '0;
      sum_msb[N-1]   = sum_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = start ? RUN : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         sum   <= (sum >> 1) | sum_msb;
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= c_next;
         cnt   <= cnt + CW'(1);
         // On the MSB, carry still holds the carry into that bit.
         if (last_bit) begin
            cout     <= c_next;
            overflow <= carry ^ c_next;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_n_bit.sv
// Directed bench for serial_adder_n_bit at N=4 with hand-computed results.
module tb_serial_adder_n_bit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [3:0] sum;
   logic       cout;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   serial_adder_n_bit #(.N(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                         input logic tc, input logic [3:0] es, input logic ec, input logic eo);
      int nb;
      bit got;
      nb  = 0;
      got = 0;
      @(negedge clk);
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      cin   = tc;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         if (done) begin
            got = 1;
         end else begin
            if (busy) nb++;
            @(negedge clk);
         end
      end
      check({tag, "_done_seen"}, got, 1);
      check({tag, "_busy_cycles"}, nb, 4);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"}, overflow, eo);
      @(negedge clk);
      check({tag, "_done_single"}, done, 0);
      check({tag, "_sum_hold"}, sum, es);
   endtask

   initial begin
      int pulses;
      int t_first;
      int t_second;
      logic [3:0] s_first;
      logic [3:0] s_second;
      bit busy_on_done_next;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", overflow, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("add3_5",  4'd3,  4'd5, 1'b0, 4'd8, 1'b0, 1'b1);
      run_op("add15_1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);
      run_op("add8_8",  4'd8,  4'd8, 1'b0, 4'd0, 1'b1, 1'b1);
      run_op("add7_0c", 4'd7,  4'd0, 1'b1, 4'd8, 1'b0, 1'b1);
      run_op("add6_9c", 4'd6,  4'd9, 1'b1, 4'd0, 1'b1, 1'b0);

      // start re-asserted during RUN must be ignored
      @(negedge clk);
      start = 1'b1; a = 4'd1; b = 4'd1; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      s_first = '0;
      for (int i = 0; i < 10; i++) begin
         if (i == 1) begin
            start = 1'b1; a = 4'd9; b = 4'd9;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            pulses++;
            s_first = sum;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("ign_pulses", pulses, 1);
      check("ign_sum", s_first, 2);

      // back-to-back with start held high
      @(negedge clk);
      start = 1'b1; a = 4'd2; b = 4'd3; cin = 1'b0;
      @(negedge clk);
      a = 4'd4; b = 4'd4;
      pulses = 0; t_first = 0; t_second = 0;
      s_first = '0; s_second = '0;
      busy_on_done_next = 0;
      for (int i = 0; i < 14; i++) begin
         if (done) begin
            pulses++;
            if (pulses == 1) begin
               t_first = i;
               s_first = sum;
            end else if (pulses == 2) begin
               t_second = i;
               s_second = sum;
            end
         end
         if (pulses == 1 && i == t_first + 1) begin
            busy_on_done_next = busy;
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("b2b_pulses", pulses, 2);
      check("b2b_spacing", t_second - t_first, 5);
      check("b2b_sum1", s_first, 5);
      check("b2b_sum2", s_second, 8);
      check("b2b_restart", busy_on_done_next, 1);
      check("b2b_ovf2", overflow, 1);

      // reset during the 3rd RUN cycle aborts the operation
      @(negedge clk);
      start = 1'b1; a = 4'd5; b = 4'd5; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum", sum, 0);
      check("abort_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) pulses++;
         @(negedge clk);
      end
      check("abort_no_done", pulses, 0);
      run_op("add5_5", 4'd5, 4'd5, 1'b0, 4'd10, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule

// File: doc/serial_adder_n_bit.md
Name: serial_adder_n_bit

Overview:
- Bit-serial N-bit adder. It is the additive counterpart of the team's ripple subtractor datapath.
- One full-adder cell plus a carry flip-flop process one operand bit per clock, LSB first.
- Operands are latched on a start handshake. The result is reported with a done pulse and held until the next operation.
- Used on the Slave side where area matters more than latency, for example accumulating received words before they are compared or subtracted.

Parameters:
- N, 4, operand and result width in bits; legal range N >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock domain.
- start  input  1  request to begin an addition; sampled on rising edge.
- a  input  N  operand A, unsigned or two's complement; sampled only when start is accepted.
- b  input  N  operand B; sampled with a.
- cin  input  1  carry-in; sampled with a.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse when the result becomes valid.
- sum  output  N  result A+B+cin mod 2^N; held stable outside RUN.
- cout  output  1  unsigned carry-out of bit N-1.
- overflow  output  1  signed overflow, defined as carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; internal operand shift registers, carry flop and bit counter cleared.
- FSM states:
  - IDLE: busy=0, done=0. If start=1 at an edge: latch a, b and cin into the operand registers and carry flop, clear the counter, go to RUN.
  - RUN: busy=1. Each edge, the full-adder cell computes sum_bit = a0^b0^c and c_next = a0&b0 | c&(a0^b0) from the LSBs of the operand shift registers.
    - Shift sum_bit into sum from the MSB side.
    - Shift both operand registers right by one.
    - Carry flop <= c_next.
    - Counter increments.
    - On the edge where counter == N-1: record the carry into the MSB (the carry-flop value before the update), set cout = c_next, overflow = carry_in_msb ^ c_next, and go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Next edge: if start=1, accept a new operation exactly as in IDLE and go to RUN (back-to-back supported). Otherwise go to IDLE.
- Latency: accepting edge E0; busy=1 after E0; edges E1..EN process bits 0..N-1; after EN, done=1, busy=0, and sum/cout/overflow are valid. Latency is N cycles from busy rising to done.
- Throughput: one addition per N+1 cycles with start held high.
- start while busy=1 is ignored. Operand inputs are don't-care except on the accepting edge.
- Output hold:
  - sum, cout and overflow keep their last completed values in IDLE and DONE.
  - During RUN, sum shifts and is not valid; consumers must qualify sum with done.
- Wrap-around: the result is mod 2^N. cout captures the lost bit. No saturation.
- N=1: single RUN cycle. carry_in_msb is the latched cin.
- Reset asserted mid-RUN aborts the operation immediately: no done pulse, and all outputs go to their reset values.
- No X propagation: every flop has a reset value.

Test Plan (N=4):
- Reset, then start with a=3, b=5, cin=0 -> busy high 4 cycles; done pulse; sum=8, cout=0, overflow=1.
- a=15, b=1, cin=0 -> sum=0, cout=1, overflow=0. Then a=8, b=8 (-8 + -8) -> sum=0, cout=1, overflow=1.
- a=7, b=0, cin=1 -> sum=8, cout=0, overflow=1. Then a=6, b=9, cin=1 -> sum=0, cout=1, overflow=0.
- start pulsed with a=1, b=1, then start re-asserted with a=9, b=9 on the 2nd RUN cycle -> ignored; done reports sum=2; exactly one done pulse.
- start held high with operand pairs (2,3) then (4,4) -> done pulses 5 cycles apart; sums 5 then 8; second operation starts on the DONE cycle.
- rst_n low for 1 cycle during the 3rd RUN cycle of a=5, b=5 -> outputs 0 immediately, no done pulse; a new start afterwards computes correctly.
